// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts a byte plus odd parity on device clock falling edges and checks the ack.
module ps2_host_tx #(
    parameter int unsigned FREQ_HZ = 40_000_000
) (
    input  logic       clk_cpu,
    input  logic       reset_n_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       done_o,
    output logic       err_o,
    output logic [1:0] err_code_o,
    input  logic       ps2_clk_i,
    output logic       ps2_clk_oe_o,
    input  logic       ps2_data_i,
    output logic       ps2_data_oe_o
);

    localparam int unsigned INHIBIT_CYC = FREQ_HZ / 10_000;
    localparam int unsigned TIMEOUT_CYC = FREQ_HZ * 15 / 1000;
    localparam int unsigned CNT_W       = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        RELEASE
    } state_t;

    state_t           state, state_next;
    logic             clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic             clk_fall, timeout, accept, in_frame;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [8:0]       frame;
    logic             clk_oe_d, data_oe_d, done_d, err_d, ready_d;

    // Synchronizers reset to the idle-high bus level so reset release cannot fake a falling edge.
    always_ff @(posedge clk_cpu or negedge reset_n_i) begin
        if (!reset_n_i) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_i;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data_i;
            dat_s2   <= dat_s1;
        end
    end

    assign clk_fall = clk_prev & ~clk_s2;
    assign in_frame = (state == SEND) || (state == ACK) || (state == RELEASE);
    assign timeout  = in_frame && (cnt == TO_LAST);
    assign accept   = (state == IDLE) && ready_o && valid_i;

    // State and registered outputs; outputs are computed from the next state so they never glitch.
    always_ff @(posedge clk_cpu or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= IDLE;
            ps2_clk_oe_o  <= 1'b0;
            ps2_data_oe_o <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            ready_o       <= 1'b1;
        end else begin
            state         <= state_next;
            ps2_clk_oe_o  <= clk_oe_d;
            ps2_data_oe_o <= data_oe_d;
            done_o        <= done_d;
            err_o         <= err_d;
            ready_o       <= ready_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = INHIBIT;
            INHIBIT: if (cnt == INH_LAST) state_next = RTS;
            RTS:     state_next = SEND;
            SEND: begin
                if (timeout)                             state_next = IDLE;
                else if (clk_fall && (bit_idx == 4'd9))  state_next = ACK;
            end
            ACK: begin
                if (timeout)       state_next = IDLE;
                else if (clk_fall) state_next = dat_s2 ? IDLE : RELEASE;
            end
            RELEASE: begin
                if (timeout || (clk_s2 && dat_s2)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        clk_oe_d  = (state_next == INHIBIT) || (state_next == RTS);
        data_oe_d = 1'b0;
        case (state_next)
            RTS: data_oe_d = 1'b1;
            SEND: begin
                if (state != SEND)  data_oe_d = 1'b1;
                else if (clk_fall)  data_oe_d = ~frame[bit_idx];
                else                data_oe_d = ps2_data_oe_o;
            end
            default: data_oe_d = 1'b0;
        endcase
        done_d  = (state == RELEASE) && !timeout && clk_s2 && dat_s2;
        err_d   = timeout || ((state == ACK) && clk_fall && dat_s2);
        // Ready is held low during a result pulse so the following cycle is always ready.
        ready_d = (state_next == IDLE) && !done_d && !err_d;
    end

    // Shared counter: inhibit length, then frame timeout running from SEND entry to the end.
    always_ff @(posedge clk_cpu or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt        <= '0;
            bit_idx    <= '0;
            frame      <= '0;
            err_code_o <= '0;
        end else begin
            case (state)
                IDLE, RTS: cnt <= '0;
                INHIBIT:   cnt <= (cnt == INH_LAST) ? '0 : cnt + 1'b1;
                default:   cnt <= cnt + 1'b1;
            endcase

            if (state == RTS)
                bit_idx <= '0;
            else if ((state == SEND) && clk_fall && !timeout)
                bit_idx <= bit_idx + 1'b1;

            if (accept) begin
                frame      <= {~^data_i, data_i};
                err_code_o <= '0;
            end else if (timeout) begin
                err_code_o <= 2'b01;
            end else if ((state == ACK) && clk_fall && dat_s2) begin
                err_code_o <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a PS/2 device model on open-collector lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int unsigned TIMEOUT_CYC = 15000;

    logic       clk_cpu = 1'b0;
    logic       reset_n_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o, done_o, err_o;
    logic [1:0] err_code_o;
    logic       ps2_clk_oe_o, ps2_data_oe_o;
    logic       dev_clk_low, dev_data_low;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~(ps2_clk_oe_o | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe_o | dev_data_low);

    ps2_host_tx #(.FREQ_HZ(1_000_000)) dut (
        .clk_cpu       (clk_cpu),
        .reset_n_i     (reset_n_i),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .err_code_o    (err_code_o),
        .ps2_clk_i     (ps2_clk_line),
        .ps2_clk_oe_o  (ps2_clk_oe_o),
        .ps2_data_i    (ps2_data_line),
        .ps2_data_oe_o (ps2_data_oe_o)
    );

    always #5 clk_cpu = ~clk_cpu;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, rts_cnt = 0, rdy_viol = 0;
    int err_cyc = 0, rts_cyc = 0;
    logic prev_pulse = 1'b0;

    always @(posedge clk_cpu) cyc++;

    always @(negedge clk_cpu) begin
        if (done_o) done_cnt++;
        if (err_o) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (done_o && err_o) both_cnt++;
        if (ps2_clk_oe_o && !ps2_data_oe_o) inh_cnt++;
        if (ps2_clk_oe_o && ps2_data_oe_o) begin
            rts_cnt++;
            rts_cyc = cyc;
        end
        if (prev_pulse && !ready_o) rdy_viol++;
        prev_pulse = done_o | err_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        ack;
        logic [10:0] frame;   // {stop, parity, d7..d0, start}
        logic [1:0]  code;
    } vec_t;

    vec_t vecs[6];

    task automatic start_send(input logic [7:0] d);
        int n = 0;
        @(negedge clk_cpu);
        while (!ready_o && n < 200) begin
            @(negedge clk_cpu);
            n++;
        end
        check("ready_before_send", {31'd0, ready_o}, 32'd1);
        data_i  = d;
        valid_i = 1'b1;
        @(negedge clk_cpu);
        valid_i = 1'b0;
    endtask

    // Waits for request-to-send release (clock high, data low), returns the start bit level.
    task automatic wait_rts(output logic start_bit, output logic ok);
        int n = 0;
        ok = 1'b1;
        while (!(ps2_clk_line && !ps2_data_line) && n < 2000) begin
            @(negedge clk_cpu);
            n++;
        end
        if (n >= 2000) ok = 1'b0;
        start_bit = ps2_data_line;
    endtask

    task automatic device_frame(input logic ack, output logic [10:0] rx, output logic ok);
        logic sb;
        rx = '1;
        wait_rts(sb, ok);
        if (!ok) return;
        rx[0] = sb;
        repeat (20) @(negedge clk_cpu);
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (40) @(negedge clk_cpu);
            dev_clk_low = 1'b0;
            rx[i] = ps2_data_line;
            repeat (40) @(negedge clk_cpu);
        end
        if (ack) dev_data_low = 1'b1;
        repeat (20) @(negedge clk_cpu);
        dev_clk_low = 1'b1;
        repeat (40) @(negedge clk_cpu);
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk_cpu);
        dev_data_low = 1'b0;
        repeat (20) @(negedge clk_cpu);
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        int d0, e0, i0, r0;
        logic [10:0] rx;
        logic ok;
        string tag;
        tag = $sformatf("v%0d_%02h", idx, v.data);
        d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt; r0 = rts_cnt;
        start_send(v.data);
        device_frame(v.ack, rx, ok);
        repeat (10) @(negedge clk_cpu);
        check({tag, "_rts_seen"}, {31'd0, ok}, 32'd1);
        check({tag, "_frame"}, {21'd0, rx}, {21'd0, v.frame});
        check({tag, "_done"}, done_cnt - d0, {31'd0, v.ack});
        check({tag, "_err"}, err_cnt - e0, {31'd0, ~v.ack});
        check({tag, "_code"}, {30'd0, err_code_o}, {30'd0, v.code});
        check({tag, "_inhibit_cycles"}, inh_cnt - i0, 32'd100);
        check({tag, "_rts_cycles"}, rts_cnt - r0, 32'd1);
        check({tag, "_clk_oe_idle"}, {31'd0, ps2_clk_oe_o}, 32'd0);
        check({tag, "_data_oe_idle"}, {31'd0, ps2_data_oe_o}, 32'd0);
        check({tag, "_ready_idle"}, {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
        logic [10:0] rx;
        logic ok, sb;
        int n, d0, e0, i0;

        vecs[0] = '{8'hF4, 1'b1, {1'b1, 1'b0, 8'hF4, 1'b0}, 2'b00};
        vecs[1] = '{8'hFF, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, 2'b00};
        vecs[2] = '{8'h00, 1'b0, {1'b1, 1'b1, 8'h00, 1'b0}, 2'b10};
        vecs[3] = '{8'h55, 1'b1, {1'b1, 1'b1, 8'h55, 1'b0}, 2'b00};
        vecs[4] = '{8'h01, 1'b1, {1'b1, 1'b0, 8'h01, 1'b0}, 2'b00};
        vecs[5] = '{8'h80, 1'b0, {1'b1, 1'b0, 8'h80, 1'b0}, 2'b10};

        reset_n_i    = 1'b0;
        data_i       = 8'h00;
        valid_i      = 1'b0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        #23;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_pulses", {30'd0, done_o, err_o}, 32'd0);
        check("rst_oe", {30'd0, ps2_clk_oe_o, ps2_data_oe_o}, 32'd0);
        check("rst_code", {30'd0, err_code_o}, 32'd0);
        @(negedge clk_cpu);
        reset_n_i = 1'b1;
        @(negedge clk_cpu);
        check("post_rst_ready", {31'd0, ready_o}, 32'd1);
        check("post_rst_pulses", {30'd0, done_o, err_o}, 32'd0);

        for (int i = 0; i < 6; i++) run_vector(vecs[i], i);

        // Second request during INHIBIT is ignored; data_i changes do not reach the frame.
        d0 = done_cnt; i0 = inh_cnt;
        start_send(8'hF4);
        repeat (30) @(negedge clk_cpu);
        data_i  = 8'h55;
        valid_i = 1'b1;
        @(negedge clk_cpu);
        valid_i = 1'b0;
        device_frame(1'b1, rx, ok);
        repeat (200) @(negedge clk_cpu);
        check("busy_rts_seen", {31'd0, ok}, 32'd1);
        check("busy_frame", {21'd0, rx}, {21'd0, 1'b1, 1'b0, 8'hF4, 1'b0});
        check("busy_done", done_cnt - d0, 32'd1);
        check("busy_inhibit_once", inh_cnt - i0, 32'd100);

        // No device clock: timeout counted from the first SEND cycle (the one after RTS).
        d0 = done_cnt; e0 = err_cnt;
        start_send(8'hAA);
        n = 0;
        while (!err_o && n < 20000) begin
            @(negedge clk_cpu);
            n++;
        end
        check("to_err_seen", {31'd0, err_o}, 32'd1);
        @(negedge clk_cpu);
        check("to_latency", err_cyc - rts_cyc, TIMEOUT_CYC + 1);
        check("to_code", {30'd0, err_code_o}, 32'd1);
        check("to_ready_next", {31'd0, ready_o}, 32'd1);
        check("to_oe", {30'd0, ps2_clk_oe_o, ps2_data_oe_o}, 32'd0);
        check("to_err_once", err_cnt - e0, 32'd1);
        check("to_no_done", done_cnt - d0, 32'd0);

        // Asynchronous reset during INHIBIT.
        start_send(8'hF4);
        repeat (30) @(negedge clk_cpu);
        check("inh_pre_clk_oe", {31'd0, ps2_clk_oe_o}, 32'd1);
        #2 reset_n_i = 1'b0;
        #1;
        check("inh_rst_clk_oe", {31'd0, ps2_clk_oe_o}, 32'd0);
        check("inh_rst_ready", {31'd0, ready_o}, 32'd1);
        @(negedge clk_cpu);
        reset_n_i = 1'b1;

        // Asynchronous reset while data bit 5 is on the line.
        start_send(8'hF4);
        wait_rts(sb, ok);
        check("b5_rts_seen", {31'd0, ok}, 32'd1);
        repeat (20) @(negedge clk_cpu);
        for (int i = 1; i <= 6; i++) begin
            dev_clk_low = 1'b1;
            repeat (40) @(negedge clk_cpu);
            if (i < 6) begin
                dev_clk_low = 1'b0;
                repeat (40) @(negedge clk_cpu);
            end
        end
        check("b5_pre_ready", {31'd0, ready_o}, 32'd0);
        #2 reset_n_i = 1'b0;
        #1;
        check("b5_rst_oe", {30'd0, ps2_clk_oe_o, ps2_data_oe_o}, 32'd0);
        check("b5_rst_ready", {31'd0, ready_o}, 32'd1);
        check("b5_rst_pulses", {30'd0, done_o, err_o}, 32'd0);
        check("b5_rst_code", {30'd0, err_code_o}, 32'd0);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk_cpu);
        reset_n_i = 1'b1;
        @(negedge clk_cpu);
        check("b5_post_ready", {31'd0, ready_o}, 32'd1);
        run_vector(vecs[0], 6);

        check("never_done_and_err", both_cnt, 32'd0);
        check("ready_after_pulse", rdy_viol, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter FREQ_HZ, default 40_000_000, clk_cpu frequency in Hz.
REQ-002 SHALL have port clk_cpu  input  1  system clock; all logic in this single domain.
REQ-003 SHALL have port reset_n_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port data_i  input  8  command byte to send.
REQ-005 SHALL have port valid_i  input  1  send request, qualified by ready_o.
REQ-006 SHALL have port ready_o  output  1  high only in IDLE.
REQ-007 SHALL have port done_o  output  1  one-cycle pulse on acknowledged completion.
REQ-008 SHALL have port err_o  output  1  one-cycle pulse on failure.
REQ-009 SHALL have port err_code_o  output  2  01 timeout, 10 no ack; held until the next accepted request.
REQ-010 SHALL have port ps2_clk_i  input  1  PS/2 clock line level.
REQ-011 SHALL have port ps2_clk_oe_o  output  1  1 = drive clock line low, 0 = release.
REQ-012 SHALL have port ps2_data_i  input  1  PS/2 data line level.
REQ-013 SHALL have port ps2_data_oe_o  output  1  1 = drive data line low, 0 = release.

Function
REQ-014 SHALL pass ps2_clk_i and ps2_data_i through 2-FF synchronizers before any use.
REQ-015 SHALL detect a clock falling edge as synced clock 1 in the previous cycle and 0 in the current cycle.
REQ-016 SHALL define INHIBIT_CYC = FREQ_HZ/10_000 (100 us) and TIMEOUT_CYC = FREQ_HZ*15/1000 (15 ms); counter widths via $clog2.
REQ-017 SHALL implement the states IDLE, INHIBIT, RTS, SEND, ACK, RELEASE.
REQ-018 IDLE: both oe outputs 0 and ready_o=1.
REQ-019 IDLE: when valid_i=1, SHALL latch data_i, latch odd parity (~^data_i), clear err_code_o, and go to INHIBIT.
REQ-020 INHIBIT: ps2_clk_oe_o=1 and ps2_data_oe_o=0 for exactly INHIBIT_CYC cycles, then go to RTS.
REQ-021 RTS: both oe outputs 1 for exactly one cycle, then go to SEND with bit index 0 and the timeout counter cleared.
REQ-022 SEND: ps2_clk_oe_o=0; ps2_data_oe_o stays 1 (start bit) until the first falling edge.
REQ-023 SEND, falling edges 1-8: ps2_data_oe_o = ~data[n-1] (LSB first).
REQ-024 SEND, falling edge 9: ps2_data_oe_o = ~parity.
REQ-025 SEND, falling edge 10: ps2_data_oe_o = 0 (stop bit); go to ACK.
REQ-026 ACK: on the next (11th) falling edge, sample the synced data line; 0 -> RELEASE; 1 -> err_o pulse, err_code_o=10, go to IDLE.
REQ-027 RELEASE: wait until both synced lines are 1, then pulse done_o for one cycle and go to IDLE.
REQ-028 Timeout counter SHALL run continuously from entry to SEND through ACK and RELEASE.
REQ-029 Reaching TIMEOUT_CYC in SEND, ACK or RELEASE SHALL pulse err_o, set err_code_o=01, release both lines and go to IDLE.
REQ-030 If a timeout and a falling edge occur in the same cycle, the timeout SHALL win.
REQ-031 valid_i SHALL be ignored outside IDLE; changes to data_i after acceptance SHALL not affect the frame.
REQ-032 done_o and err_o SHALL never be high in the same cycle; each SHALL pulse at most once per accepted request.
REQ-033 ready_o SHALL be 1 in the cycle following any done_o or err_o pulse.
REQ-034 All outputs SHALL be registered; the oe outputs SHALL be glitch-free.

Reset
REQ-035 Asserting reset_n_i=0 SHALL immediately and asynchronously force both oe outputs, done_o, err_o and err_code_o to 0, ready_o to 1, and the state to IDLE, including mid-frame.
REQ-036 After reset_n_i deasserts, the block SHALL be ready on the first clock with no spurious pulses.

Verification (FREQ_HZ=1_000_000: INHIBIT_CYC=100, TIMEOUT_CYC=15000; device model drives an approx. 12.5 kHz clock, samples on rising edges)
REQ-037 Send 0xF4 -> clk_oe=1 for 100 cycles, one RTS cycle, then device sees start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1; device acks -> exactly one done_o, err_o never high.
REQ-038 Send 0xFF -> parity bit 1, done_o pulses once.
REQ-039 Send 0x00 with the device model leaving data high on the 11th edge -> err_o pulse, err_code_o=10, no done_o, both oe outputs 0.
REQ-040 Send with no device clock -> err_o exactly 15000 cycles after RTS exit, err_code_o=01, ready_o=1 in the next cycle.
REQ-041 Assert reset_n_i during bit 5 -> both oe outputs 0 in the same cycle without a clock edge; the next send of 0xF4 completes normally.
REQ-042 Pulse valid_i with 0x55 during INHIBIT of a 0xF4 frame -> only 0xF4 is transmitted and only one done_o occurs.
